// File: rtl/state_pkg.sv
// state_pkg: player animation state and jump phase enums shared by the player/sprite stages.
package state_pkg;
  typedef enum logic [1:0] {IDLE, RIGHT, LEFT} State;
  typedef enum logic [1:0] {GROUND, RISE, FALL} jump_t;
endpackage

// File: rtl/player_ctl_if.sv
// player_ctl_if: frame sync and key levels into the player controller, position and state out.
interface player_ctl_if;
  import state_pkg::*;
  logic        vsync;
  logic        key_left;
  logic        key_right;
  logic        key_jump;
  logic [11:0] xpos_player;
  logic [11:0] ypos_player;
  State        state;
  modport master (output vsync, key_left, key_right, key_jump, input xpos_player, ypos_player, state);
  modport slave (input vsync, key_left, key_right, key_jump, output xpos_player, ypos_player, state);
endinterface

// File: rtl/player_ctl_edge_rise.sv
// edge_rise: registered rising-edge detector; pulse is high for one cycle after d rises.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic d_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q   <= 1'b0;
      pulse <= 1'b0;
    end else begin
      d_q   <= d;
      pulse <= d & ~d_q;
    end
  end
endmodule

// File: rtl/player_ctl.sv
// player_ctl: per-frame player position/state update from key levels, ticked by vsync rising edge.
// Jumping is built only when PLAYER_JUMP_EN is defined; otherwise ypos is fixed at Y_GROUND.
module player_ctl
  import state_pkg::*;
#(
  parameter logic [11:0] X_START   = 12'd300,
  parameter logic [11:0] X_MIN     = 12'd0,
  parameter logic [11:0] X_MAX     = 12'd984,
  parameter logic [11:0] SPEED     = 12'd4,
  parameter logic [11:0] Y_GROUND  = 12'd100,
  parameter logic [11:0] JUMP_H    = 12'd80,
  parameter logic [11:0] JUMP_STEP = 12'd5
) (
  input logic clk,
  input logic rst,
  player_ctl_if.slave bus
);
  logic tick, left, right;
  logic [11:0] x_q, x_d;
  State st_q, st_d;
  edge_rise u_tick (.clk(clk), .rst(rst), .d(bus.vsync), .pulse(tick));
  assign left  = bus.key_left & ~bus.key_right;
  assign right = bus.key_right & ~bus.key_left;
`ifdef PLAYER_JUMP_EN
  localparam logic [11:0] APEX = Y_GROUND - JUMP_H;
  logic [11:0] y_q, y_d, rise_y, fall_y;
  jump_t j_q, j_d;
  logic l_q, l_d;
`endif
  always_comb begin
    x_d  = x_q;
    st_d = st_q;
    if (tick) begin
      st_d = left ? LEFT : right ? RIGHT : IDLE;
      x_d  = left ? (({1'b0, x_q} < {1'b0, X_MIN} + {1'b0, SPEED}) ? X_MIN : x_q - SPEED) :
             right ? (({1'b0, x_q} + {1'b0, SPEED} > {1'b0, X_MAX}) ? X_MAX : x_q + SPEED) : x_q;
    end
`ifdef PLAYER_JUMP_EN
    y_d    = y_q;
    j_d    = j_q;
    rise_y = ({1'b0, y_q} < {1'b0, APEX} + {1'b0, JUMP_STEP}) ? APEX : y_q - JUMP_STEP;
    fall_y = ({1'b0, y_q} + {1'b0, JUMP_STEP} > {1'b0, Y_GROUND}) ? Y_GROUND : y_q + JUMP_STEP;
    // latch only collects presses on the ground and is consumed by the next ground tick
    l_d    = (j_q == GROUND && !tick) ? (l_q | bus.key_jump) : 1'b0;
    if (tick && j_q == FALL) begin
      y_d = fall_y;
      j_d = (fall_y == Y_GROUND) ? GROUND : FALL;
    end else if (tick && (j_q == RISE || l_q)) begin
      y_d = rise_y;
      j_d = (rise_y == APEX) ? FALL : RISE;
    end
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q  <= X_START;
      st_q <= IDLE;
`ifdef PLAYER_JUMP_EN
      y_q  <= Y_GROUND;
      j_q  <= GROUND;
      l_q  <= 1'b0;
`endif
    end else begin
      x_q  <= x_d;
      st_q <= st_d;
`ifdef PLAYER_JUMP_EN
      y_q  <= y_d;
      j_q  <= j_d;
      l_q  <= l_d;
`endif
    end
  end
  assign bus.xpos_player = x_q;
  assign bus.state       = st_q;
`ifdef PLAYER_JUMP_EN
  assign bus.ypos_player = y_q;
`else
  logic unused_jump;
  assign unused_jump     = ^{bus.key_jump, JUMP_H, JUMP_STEP};
  assign bus.ypos_player = Y_GROUND;
`endif
endmodule

// File: tb/tb_player_ctl.sv
// tb_player_ctl: scoreboard bench for player_ctl; two instances (X_START 300 and 2) share the keys.
module tb_player_ctl;
  import state_pkg::*;
  typedef struct {
    logic [11:0] x0;
    logic [11:0] x1;
    logic [11:0] y;
    State        st;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  exp_t q[$];
  exp_t cur;
  logic [11:0] mx0, mx1, my;
  State ms;
  jump_t mj;
  logic ml;
  always #5 clk = ~clk;
  player_ctl_if b0 ();
  player_ctl_if b1 ();
  assign b1.vsync     = b0.vsync;
  assign b1.key_left  = b0.key_left;
  assign b1.key_right = b0.key_right;
  assign b1.key_jump  = b0.key_jump;
  player_ctl u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  player_ctl #(.X_START(12'd2)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [11:0] hx(input logic [11:0] x, input logic l, input logic r);
    if (l && !r) return (x < 12'd4) ? 12'd0 : x - 12'd4;
    if (r && !l) return (x > 12'd980) ? 12'd984 : x + 12'd4;
    return x;
  endfunction
  task automatic model_reset();
    mx0 = 12'd300; mx1 = 12'd2; my = 12'd100; ms = IDLE; mj = GROUND; ml = 1'b0;
    cur = '{mx0, mx1, my, ms};
  endtask
  task automatic model_tick(input logic l, input logic r);
    mx0 = hx(mx0, l, r);
    mx1 = hx(mx1, l, r);
    ms  = (l && !r) ? LEFT : (r && !l) ? RIGHT : IDLE;
`ifdef PLAYER_JUMP_EN
    if (mj == GROUND) begin
      if (ml) begin mj = RISE; my = my - 12'd5; end
      ml = 1'b0;
    end else if (mj == RISE) begin
      my = my - 12'd5;
      if (my == 12'd20) mj = FALL;
    end else begin
      my = my + 12'd5;
      if (my == 12'd100) mj = GROUND;
    end
`endif
  endtask
  task automatic check_all(input string tag, input exp_t e);
    chk({tag, "_x0"}, 32'(b0.xpos_player), 32'(e.x0));
    chk({tag, "_x1"}, 32'(b1.xpos_player), 32'(e.x1));
    chk({tag, "_y"}, 32'(b0.ypos_player), 32'(e.y));
    chk({tag, "_st"}, 32'(b0.state), 32'(e.st));
  endtask
  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    check_all("reset", cur);
    rst = 1'b0;
  endtask
  task automatic frame(input string tag, input logic l, input logic r);
    exp_t e;
    b0.key_left = l; b0.key_right = r;
    @(negedge clk); b0.vsync = 1'b1;
    model_tick(l, r);
    q.push_back('{mx0, mx1, my, ms});
    @(posedge clk); #1;
    chk({tag, "_hold_x"}, 32'(b0.xpos_player), 32'(cur.x0));
    chk({tag, "_hold_y"}, 32'(b0.ypos_player), 32'(cur.y));
    @(posedge clk); #1;
    e = q.pop_front();
    check_all(tag, e);
    cur = e;
    @(negedge clk); b0.vsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic jump_pulse();
    @(negedge clk); b0.key_jump = 1'b1;
    @(negedge clk); b0.key_jump = 1'b0;
`ifdef PLAYER_JUMP_EN
    if (mj == GROUND) ml = 1'b1;
`endif
  endtask
  initial begin
    b0.vsync = 1'b0; b0.key_left = 1'b0; b0.key_right = 1'b0; b0.key_jump = 1'b0;
    do_reset();
    frame("idle", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) frame("right3", 1'b0, 1'b1);
    frame("both", 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) frame("left_clamp", 1'b1, 1'b0);
    do_reset();
    for (int i = 0; i < 246; i++) frame("right_run", 1'b0, 1'b1);
    b0.key_right = 1'b0;
    jump_pulse();
`ifdef PLAYER_JUMP_EN
    for (int i = 0; i < 32; i++) begin
      frame("jump", 1'b0, 1'b0);
      if (i == 5) jump_pulse();
    end
    frame("landed", 1'b0, 1'b0);
`else
    for (int i = 0; i < 40; i++) frame("nojump", 1'b0, 1'b0);
`endif
    do_reset();
    for (int i = 0; i < 2; i++) frame("pre_rst", 1'b0, 1'b1);
`ifdef PLAYER_JUMP_EN
    jump_pulse();
    for (int i = 0; i < 10; i++) frame("mid_jump", 1'b0, 1'b1);
    chk("mid_jump_y50", 32'(b0.ypos_player), 32'd50);
`endif
    b0.key_right = 1'b1;
    @(negedge clk); b0.vsync = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check_all("rst_tick", cur);
    @(negedge clk); rst = 1'b0; b0.vsync = 1'b0; b0.key_right = 1'b0;
    repeat (3) @(negedge clk);
    check_all("rst_hold", cur);
    for (int i = 0; i < 3; i++) frame("post_rst", 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
